// File: rtl/saturn_bus_sequencer.sv
// saturn_bus_sequencer: buffers one bus command program from the control unit
// (requester 0) or the debugger (requester 1), then streams it to the bus
// controller one entry per phase-0 slot, stalling while the bus is busy.
//
// Handshake: a requester entry transfers on a rising i_clk edge where
// i_reqX_valid and o_reqX_ready are both high. o_reqX_ready depends only on
// state, owner and i_clk_en, never on valid. The requester holds data/last
// stable while valid is high and not yet accepted. o_bus_cmd_valid is a
// single-cycle strobe with no back-pressure; i_bus_busy instead blocks the
// issue itself.
module saturn_bus_sequencer #(
  parameter int DEPTH = 32
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clk_en,
  input  logic [3:0] i_phases,
  input  logic       i_bus_busy,
  input  logic       i_req0_valid,
  input  logic [4:0] i_req0_data,
  input  logic       i_req0_last,
  input  logic       i_req1_valid,
  input  logic [4:0] i_req1_data,
  input  logic       i_req1_last,
  output logic       o_req0_ready,
  output logic       o_req1_ready,
  output logic       o_bus_cmd_valid,
  output logic [4:0] o_bus_cmd,
  output logic       o_owner,
  output logic       o_busy,
  output logic       o_error,
  output logic [1:0] o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            prio_q, prio_d;
  logic            error_q, error_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   len_q, len_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [4:0]      cmd_q, cmd_d;
  logic [4:0]      buf_q [DEPTH];

  // Only the phase-0 strobe matters; the other phases are intentionally ignored.
  logic            unused_phases;
  assign unused_phases = ^i_phases[3:1];

  // Mux the granted requester's channel.
  logic            own_valid;
  logic [4:0]      own_data;
  logic            own_last;
  assign own_valid = owner_q ? i_req1_valid : i_req0_valid;
  assign own_data  = owner_q ? i_req1_data  : i_req0_data;
  assign own_last  = owner_q ? i_req1_last  : i_req0_last;

  logic fill_accept;
  logic issue;
  assign fill_accept = (state_q == ST_FILL) && i_clk_en && own_valid;
  assign issue       = (state_q == ST_DRAIN) && i_clk_en && i_phases[0] && !i_bus_busy;

  assign o_req0_ready    = (state_q == ST_FILL) && !owner_q && i_clk_en;
  assign o_req1_ready    = (state_q == ST_FILL) &&  owner_q && i_clk_en;
  assign o_bus_cmd_valid = cmd_valid_q;
  assign o_bus_cmd       = cmd_q;
  assign o_owner         = owner_q;
  assign o_busy          = (state_q != ST_IDLE);
  assign o_error         = error_q;
  assign o_dbg_state     = state_q;

  // Next-state logic: grant, fill with error detection, and paced drain.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    error_d     = error_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    // The strobe lasts one clock regardless of the enable; the data holds.
    cmd_valid_d = issue;
    cmd_d       = issue ? buf_q[rd_ptr_q[AW-1:0]] : cmd_q;

    if (i_clk_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_req0_valid || i_req1_valid) begin
            if (i_req0_valid && i_req1_valid) begin
              owner_d = prio_q;
            end else begin
              owner_d = i_req1_valid;
            end
            wr_cnt_d = '0;
            rd_ptr_d = '0;
            state_d  = ST_FILL;
          end
        end
        ST_FILL: begin
          if (own_valid) begin
            if ((wr_cnt_q == '0) && !own_data[4]) begin
              // A program must open with a command; drop it, keep the owner.
              error_d  = 1'b1;
              wr_cnt_d = '0;
              state_d  = ST_IDLE;
            end else if (own_last) begin
              len_d    = wr_cnt_q + CW'(1);
              wr_cnt_d = wr_cnt_q + CW'(1);
              rd_ptr_d = '0;
              state_d  = ST_DRAIN;
            end else if (wr_cnt_q == CW'(DEPTH - 1)) begin
              // Buffer full and the program keeps going: overflow.
              error_d  = 1'b1;
              wr_cnt_d = '0;
              state_d  = ST_IDLE;
            end else begin
              wr_cnt_d = wr_cnt_q + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (i_phases[0] && !i_bus_busy) begin
            if (rd_ptr_q == len_q - CW'(1)) begin
              wr_cnt_d = '0;
              rd_ptr_d = '0;
              prio_d   = ~owner_q;
              state_d  = ST_IDLE;
            end else begin
              rd_ptr_d = rd_ptr_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and the registered bus outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      error_q     <= 1'b0;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      error_q     <= error_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  // Program storage; contents are only meaningful below wr_cnt, so no reset.
  always_ff @(posedge i_clk) begin
    if (fill_accept) begin
      buf_q[wr_cnt_q[AW-1:0]] <= own_data;
    end
  end

endmodule

// File: tb/tb_saturn_bus_sequencer.sv
// Bench for saturn_bus_sequencer: directed programs with a scoreboard of
// expected {owner, cmd} pairs checked by an independent bus monitor.
module tb_saturn_bus_sequencer;

  logic       i_clk;
  logic       i_reset_n;
  logic       i_clk_en;
  logic [3:0] i_phases;
  logic       i_bus_busy;
  logic       i_req0_valid, i_req1_valid;
  logic [4:0] i_req0_data, i_req1_data;
  logic       i_req0_last, i_req1_last;
  logic       o_req0_ready, o_req1_ready;
  logic       o_bus_cmd_valid;
  logic [4:0] o_bus_cmd;
  logic       o_owner, o_busy, o_error;
  logic [1:0] o_dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_cyc[$];
  logic [5:0] exp_q[$];
  logic [4:0] prog0 [64];
  logic [4:0] prog1 [64];

  saturn_bus_sequencer #(.DEPTH(32)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clk_en(i_clk_en),
    .i_phases(i_phases), .i_bus_busy(i_bus_busy),
    .i_req0_valid(i_req0_valid), .i_req0_data(i_req0_data), .i_req0_last(i_req0_last),
    .i_req1_valid(i_req1_valid), .i_req1_data(i_req1_data), .i_req1_last(i_req1_last),
    .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
    .o_bus_cmd_valid(o_bus_cmd_valid), .o_bus_cmd(o_bus_cmd),
    .o_owner(o_owner), .o_busy(o_busy), .o_error(o_error), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset / phase rotation ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    forever begin
      @(posedge i_clk);
      cyc++;
    end
  end

  initial begin
    i_phases = 4'b0001;
    forever begin
      @(posedge i_clk);
      #1;
      i_phases = {i_phases[2:0], i_phases[3]};
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge i_clk);
      if (i_reset_n && o_bus_cmd_valid) begin
        strobe_cnt++;
        strobe_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got=%0h expected=none (t=%0t)",
                   {o_owner, o_bus_cmd}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("bus_owner_cmd", {26'd0, o_owner, o_bus_cmd}, {26'd0, e});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int req, input logic v, input logic [4:0] d, input logic l);
    if (req == 0) begin
      i_req0_valid = v; i_req0_data = d; i_req0_last = l;
    end else begin
      i_req1_valid = v; i_req1_data = d; i_req1_last = l;
    end
  endtask

  task automatic push_prog(input int req, input int n);
    for (int k = 0; k < n; k++) begin
      if (req == 0) exp_q.push_back({1'b0, prog0[k]});
      else          exp_q.push_back({1'b1, prog1[k]});
    end
  endtask

  task automatic send_program(input int req, input int n, input bit abort_on_err,
                              output int accepted);
    int t;
    logic rdy;
    accepted = 0;
    for (int k = 0; k < n; k++) begin
      drive(req, 1'b1, (req == 0) ? prog0[k] : prog1[k], k == n - 1);
      t = 0;
      forever begin
        @(negedge i_clk);
        rdy = (req == 0) ? o_req0_ready : o_req1_ready;
        if (rdy) break;
        t++;
        if (t > 1000) break;
      end
      if (!rdy) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got=0 expected=1 (req=%0d entry=%0d)", req, k);
        drive(req, 1'b0, 5'd0, 1'b0);
        return;
      end
      @(posedge i_clk);
      #1;
      accepted++;
      if (abort_on_err && o_error) break;
    end
    drive(req, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    forever begin
      @(negedge i_clk);
      #1;
      if (!o_busy && exp_q.size() == 0) break;
      t++;
      if (t > 3000) break;
    end
    if (t > 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: got=busy expected=idle", name);
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic wait_strobes(input int target);
    int t;
    t = 0;
    while (strobe_cnt < target && t < 2000) begin
      @(negedge i_clk);
      #1;
      t++;
    end
    if (strobe_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL strobe_wait: got=%0d expected=%0d", strobe_cnt, target);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc0, acc1, base, c0, c1;
    i_reset_n = 1'b0;
    i_clk_en  = 1'b1;
    i_bus_busy = 1'b0;
    drive(0, 1'b0, 5'd0, 1'b0);
    drive(1, 1'b0, 5'd0, 1'b0);
    repeat (3) @(negedge i_clk);

    // Reset values
    chk("rst_cmd_valid", {31'd0, o_bus_cmd_valid}, 0);
    chk("rst_cmd", {27'd0, o_bus_cmd}, 0);
    chk("rst_owner", {31'd0, o_owner}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_error", {31'd0, o_error}, 0);
    chk("rst_ready", {30'd0, o_req1_ready, o_req0_ready}, 0);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Both requesters valid after reset: control unit first, then debugger.
    prog0[0] = 5'h11; prog0[1] = 5'h01; prog0[2] = 5'h02;
    prog1[0] = 5'h18; prog1[1] = 5'h0A; prog1[2] = 5'h0B; prog1[3] = 5'h0C;
    push_prog(0, 3);
    push_prog(1, 4);
    fork
      send_program(0, 3, 1'b0, acc0);
      send_program(1, 4, 1'b0, acc1);
    join
    wait_idle("both");
    chk("both_acc1", acc1, 4);

    // Six-entry program from the control unit with no busy.
    prog0[0] = 5'h10;
    for (int k = 1; k < 6; k++) prog0[k] = 5'(k - 1);
    base = strobe_cyc.size();
    push_prog(0, 6);
    send_program(0, 6, 1'b0, acc0);
    wait_idle("six");
    chk("six_count", strobe_cyc.size() - base, 6);
    for (int k = 1; k < 6; k++) begin
      if (strobe_cyc.size() > base + k)
        chk("six_gap", strobe_cyc[base + k] - strobe_cyc[base + k - 1], 4);
    end
    chk("six_busy", {31'd0, o_busy}, 0);

    // Priority now points at the debugger: contested grant goes to req1.
    // Bus busy for 3 phase-0 slots in the middle of its drain.
    prog1[0] = 5'h1F;
    for (int k = 1; k < 6; k++) prog1[k] = 5'(k + 4);
    prog0[0] = 5'h14; prog0[1] = 5'h0D;
    push_prog(1, 6);
    push_prog(0, 2);
    base = strobe_cnt;
    fork
      send_program(0, 2, 1'b0, acc0);
      send_program(1, 6, 1'b0, acc1);
      begin
        wait_strobes(base + 2);
        @(posedge i_clk);
        #1;
        i_bus_busy = 1'b1;
        @(negedge i_clk);
        #1;
        c0 = strobe_cnt;
        repeat (11) @(posedge i_clk);
        #1;
        c1 = strobe_cnt;
        i_bus_busy = 1'b0;
      end
    join
    wait_idle("busy");
    chk("busy_no_strobes", c1 - c0, 0);
    chk("busy_total", strobe_cnt - base, 8);

    // Full program of exactly DEPTH entries.
    prog0[0] = 5'h1E;
    for (int k = 1; k < 32; k++) prog0[k] = 5'(k % 16);
    push_prog(0, 32);
    base = strobe_cnt;
    send_program(0, 32, 1'b1, acc0);
    wait_idle("full");
    chk("full_count", strobe_cnt - base, 32);
    chk("full_error", {31'd0, o_error}, 0);

    // DEPTH+1 entries: overflow on the DEPTH-th accepted entry, nothing issued.
    prog0[0] = 5'h1D;
    for (int k = 1; k < 33; k++) prog0[k] = 5'((k * 3) % 16);
    base = strobe_cnt;
    send_program(0, 33, 1'b1, acc0);
    chk("ovf_accepted", acc0, 32);
    chk("ovf_error", {31'd0, o_error}, 1);
    chk("ovf_busy", {31'd0, o_busy}, 0);
    repeat (40) @(negedge i_clk);
    chk("ovf_no_strobes", strobe_cnt - base, 0);
    chk("ovf_ready0", {31'd0, o_req0_ready}, 0);

    // Reset mid-drain after 2 of 5 entries.
    prog0[0] = 5'h12; prog0[1] = 5'h01; prog0[2] = 5'h02; prog0[3] = 5'h03; prog0[4] = 5'h04;
    push_prog(0, 2);
    base = strobe_cnt;
    send_program(0, 5, 1'b0, acc0);
    wait_strobes(base + 2);
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, o_busy}, 0);
    chk("arst_cmd_valid", {31'd0, o_bus_cmd_valid}, 0);
    chk("arst_cmd", {27'd0, o_bus_cmd}, 0);
    chk("arst_error", {31'd0, o_error}, 0);
    chk("arst_state", {30'd0, o_dbg_state}, 0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    prog0[0] = 5'h13; prog0[1] = 5'h07; prog0[2] = 5'h0C;
    push_prog(0, 3);
    base = strobe_cnt;
    send_program(0, 3, 1'b0, acc0);
    wait_idle("post_rst");
    chk("post_rst_count", strobe_cnt - base, 3);

    // Program opening with a data nibble: protocol error, then a good program.
    prog0[0] = 5'h05; prog0[1] = 5'h01;
    base = strobe_cnt;
    send_program(0, 2, 1'b1, acc0);
    chk("proto_accepted", acc0, 1);
    chk("proto_error", {31'd0, o_error}, 1);
    chk("proto_busy", {31'd0, o_busy}, 0);
    prog1[0] = 5'h1A; prog1[1] = 5'h03; prog1[2] = 5'h0F;
    push_prog(1, 3);
    send_program(1, 3, 1'b0, acc1);
    wait_idle("proto_next");
    chk("proto_next_count", strobe_cnt - base, 3);
    chk("proto_sticky", {31'd0, o_error}, 1);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
